// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing one data-memory port between CPU and AUX.
// Define DMEM_ARB_BOUNDS_CHECK_EN to enable the address range check and err flags.

module dmem_arb_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              we,
    input  logic              oob,
    input  logic [DATA_W-1:0] rd_in,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err
);
    // load is high for the GNT cycle of this port, so ack/err/rdata appear in RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= load;
            err <= load & oob;
            if (load && oob)
                rdata <= '0;
            else if (load && !we)
                rdata <= rd_in;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int MEM_NIBBLES = 64,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,
    output logic              aux_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memorywrite,
    output logic              mem_memoryread,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam int NUM_PORTS = 2;

    if (MEM_NIBBLES < 8) begin : g_cfg_check
        $error("dmem_arbiter: MEM_NIBBLES must hold at least one word");
    end

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_req_t;

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_AUX, RESP} state_t;

    port_req_t [NUM_PORTS-1:0]             preq;
    port_req_t                             sel;
    state_t                                state;
    logic                                  cur;
    logic                                  last_win;
    logic      [NUM_PORTS-1:0]             elig;
    logic      [NUM_PORTS-1:0]             oob;
    logic      [NUM_PORTS-1:0]             ack_q;
    logic      [NUM_PORTS-1:0]             err_q;
    logic      [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;
    logic                                  tie;
    logic                                  pick;
    logic                                  gnt;

    assign preq[0] = '{req: cpu_req, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign preq[1] = '{req: aux_req, we: aux_we, addr: aux_addr, wdata: aux_wdata};

    // The port being acked in RESP is not eligible again until the next arbitration point
    always_comb begin
        elig = {preq[1].req, preq[0].req};
        if (state == RESP)
            elig[cur] = 1'b0;
    end

    assign tie  = &elig;
    assign pick = tie ? ~last_win : elig[1];
    assign gnt  = (state == GNT_CPU) || (state == GNT_AUX);
    assign sel  = preq[cur];

    // last_win only moves on a contested decision, so ties alternate independently of solo grants
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur      <= 1'b0;
            last_win <= 1'b1;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (|elig) begin
                        state <= pick ? GNT_AUX : GNT_CPU;
                        cur   <= pick;
                        if (tie)
                            last_win <= pick;
                    end else begin
                        state <= IDLE;
                    end
                end
                GNT_CPU, GNT_AUX: state <= RESP;
                default:          state <= IDLE;
            endcase
        end
    end

    assign mem_address     = gnt ? sel.addr  : '0;
    assign mem_write_data  = gnt ? sel.wdata : '0;
    assign mem_memorywrite = gnt &  sel.we & ~oob[cur];
    assign mem_memoryread  = gnt & ~sel.we & ~oob[cur];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_NIBBLES - 8);
        assign oob[p] = preq[p].addr > MAX_ADDR;
`else
        assign oob[p] = 1'b0;
`endif
        dmem_arb_port #(.DATA_W(DATA_W)) u_port (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (gnt && (cur == 1'(p))),
            .we      (preq[p].we),
            .oob     (oob[p]),
            .rd_in   (mem_read_data),
            .rdata   (rdata_q[p]),
            .ack     (ack_q[p]),
            .err     (err_q[p])
        );
    end

    assign cpu_rdata = rdata_q[0];
    assign cpu_ack   = ack_q[0];
    assign cpu_err   = err_q[0];
    assign aux_rdata = rdata_q[1];
    assign aux_ack   = ack_q[1];
    assign aux_err   = err_q[1];
    assign cpu_stall = cpu_req & ~cpu_ack;

    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) !(cpu_ack && aux_ack));
    a_ctrl_excl:  assert property (@(posedge clk) disable iff (!reset_n) !(mem_memorywrite && mem_memoryread));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a transaction-level scheduling model.
// Honours DMEM_ARB_BOUNDS_CHECK_EN the same way the design does.

module tb_dmem_arbiter;
    localparam int MEM_NIBBLES = 64;
    localparam int MAXA        = MEM_NIBBLES - 8;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0;
    logic cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
    logic aux_req, aux_we, aux_ack, aux_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, aux_addr, aux_wdata, aux_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic mem_memorywrite, mem_memoryread;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_NIBBLES(MEM_NIBBLES), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_rdata(aux_rdata), .aux_ack(aux_ack), .aux_err(aux_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memorywrite(mem_memorywrite), .mem_memoryread(mem_memoryread),
        .mem_read_data(mem_read_data)
    );

    // Memory device seen by the DUT: nibble array, combinational read, write on clock edge
    logic [3:0] dev_nib [MEM_NIBBLES];
    logic [3:0] ref_nib [MEM_NIBBLES];

    always_comb begin
        mem_read_data = '0;
        for (int k = 0; k < 8; k++)
            if (longint'(mem_address) + k < MEM_NIBBLES)
                mem_read_data[4*k +: 4] = dev_nib[int'(mem_address) + k];
    end

    always @(posedge clk)
        if (mem_memorywrite)
            for (int k = 0; k < 8; k++)
                if (longint'(mem_address) + k < MEM_NIBBLES)
                    dev_nib[int'(mem_address) + k] <= mem_write_data[4*k +: 4];

    function automatic logic [31:0] dev_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 8; k++)
            if (longint'(a) + k < MEM_NIBBLES) w[4*k +: 4] = dev_nib[int'(a) + k];
        return w;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 8; k++)
            if (longint'(a) + k < MEM_NIBBLES) w[4*k +: 4] = ref_nib[int'(a) + k];
        return w;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 8; k++)
            if (longint'(a) + k < MEM_NIBBLES) ref_nib[int'(a) + k] = d[4*k +: 4];
    endtask

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    // Model state: index 0 = CPU, 1 = AUX
    txn_t        q [2][$];
    txn_t        cur [2];
    bit          busy [2], granted [2], pend_err [2];
    int          exp_ack [2], issue_cyc [2];
    logic [31:0] hold [2], pend_rd [2];
    int          cyc = 0, arb_at = 0, gnt_cyc = -1, gnt_p = 0;
    bit          last = 1'b1;
    int          ack_p_log [$], ack_cyc_log [$];
    logic [31:0] ack_rd_log [$], ack_err_log [$];

    task automatic drive(input int p, input logic r, input txn_t t);
        if (p == 0) begin cpu_req = r; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata; end
        else        begin aux_req = r; aux_we = t.we; aux_addr = t.addr; aux_wdata = t.wdata; end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) cpu_req = r; else aux_req = r;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            busy[p] = 0; granted[p] = 0; pend_err[p] = 0;
            exp_ack[p] = -1; hold[p] = '0; q[p].delete();
            set_req(p, 1'b0);
        end
        last = 1'b1; gnt_cyc = -1; arb_at = cyc + 1;
    endtask

    task automatic clear_logs();
        ack_p_log.delete(); ack_cyc_log.delete(); ack_rd_log.delete(); ack_err_log.delete();
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input int gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
        q[p].push_back(t);
    endtask

    task automatic step();
        logic a, e;
        logic [31:0] rd;
        bit   ea;
        txn_t t;
        @(posedge clk); #1; cyc++;
        for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? cpu_ack   : aux_ack;
            e  = (p == 0) ? cpu_err   : aux_err;
            rd = (p == 0) ? cpu_rdata : aux_rdata;
            ea = (exp_ack[p] == cyc);
            if (ea) begin
                if (pend_err[p]) hold[p] = '0;
                else if (!cur[p].we) hold[p] = pend_rd[p];
            end
            chk((p == 0) ? "cpu_ack" : "aux_ack", a, ea);
            chk((p == 0) ? "cpu_err" : "aux_err", e, ea && pend_err[p]);
            chk((p == 0) ? "cpu_rdata" : "aux_rdata", rd, hold[p]);
            if (a) begin
                ack_p_log.push_back(p); ack_cyc_log.push_back(cyc);
                ack_rd_log.push_back(rd); ack_err_log.push_back(e);
            end
        end
        if (cyc == gnt_cyc) begin
            t = cur[gnt_p];
            chk("mem_wr", mem_memorywrite, t.we && !pend_err[gnt_p]);
            chk("mem_rd", mem_memoryread, !t.we && !pend_err[gnt_p]);
            chk("mem_addr", mem_address, t.addr);
            chk("mem_wdata", mem_write_data, t.wdata);
        end else begin
            chk("mem_ctrl_idle", {mem_memorywrite, mem_memoryread}, 0);
            chk("mem_addr_idle", mem_address, 0);
            chk("mem_wdata_idle", mem_write_data, 0);
        end
        chk("cpu_stall", cpu_stall, cpu_req && !(exp_ack[0] == cyc));
        // drivers: drop req in the ack cycle, otherwise issue the next queued transaction
        for (int p = 0; p < 2; p++) begin
            if (exp_ack[p] == cyc) begin
                busy[p] = 0; granted[p] = 0; set_req(p, 1'b0);
            end else if (!busy[p] && q[p].size() > 0) begin
                if (q[p][0].gap > 0) q[p][0].gap = q[p][0].gap - 1;
                else begin
                    cur[p] = q[p].pop_front(); busy[p] = 1; issue_cyc[p] = cyc;
                    drive(p, 1'b1, cur[p]);
                end
            end
        end
        // scheduler: arbitration points are idle cycles and ack cycles
        if (cyc == arb_at) begin
            bit e0, e1;
            int g;
            e0 = busy[0] && !granted[0];
            e1 = busy[1] && !granted[1];
            if (e0 || e1) begin
                if (e0 && e1) begin g = last ? 0 : 1; last = (g == 1); end
                else g = e1 ? 1 : 0;
                granted[g] = 1; exp_ack[g] = cyc + 2; gnt_cyc = cyc + 1; gnt_p = g;
                pend_err[g] = BCHK && (cur[g].addr > 32'(MAXA));
                if (!pend_err[g]) begin
                    if (cur[g].we) ref_write(cur[g].addr, cur[g].wdata);
                    else pend_rd[g] = ref_word(cur[g].addr);
                end
                arb_at = cyc + 2;
            end else arb_at = cyc + 1;
        end
    endtask

    task automatic run(input int maxc);
        int n = 0;
        while ((busy[0] || busy[1] || q[0].size() > 0 || q[1].size() > 0) && n < maxc) begin
            step(); n++;
        end
        if (n >= maxc) chk("timeout", 1, 0);
        step(); step();
    endtask

    initial begin
        txn_t z;
        int   n;
        logic [31:0] ra;
        z.we = 0; z.addr = 0; z.wdata = 0; z.gap = 0;
        drive(0, 1'b0, z); drive(1, 1'b0, z);
        for (int i = 0; i < MEM_NIBBLES; i++) begin
            dev_nib[i] = (i % 8 == 0) ? 4'(i / 8 + 1) : 4'h0;
            ref_nib[i] = dev_nib[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {cpu_ack, aux_ack, cpu_err, aux_err}, 0);
        chk("rst_rdata", cpu_rdata | aux_rdata, 0);
        chk("rst_mem", {mem_memorywrite, mem_memoryread}, 0);
        chk("rst_addr", mem_address, 0);
        reset_n = 1'b1;
        model_reset();

        // single read from idle: ack two cycles after the request is seen
        clear_logs(); push(0, 0, 0, 0, 0); run(50);
        chk("t1_rdata", cpu_rdata, 32'h1);
        chk("t1_lat", (ack_cyc_log.size() > 0) ? ack_cyc_log[0] - issue_cyc[0] : -1, 2);

        // write then read back
        push(0, 1, 8, 32'hDEADBEEF, 0); push(0, 0, 8, 0, 0); run(50);
        chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t2_mem", dev_word(8), 32'hDEADBEEF);

        // simultaneous requests: CPU wins the first tie, AUX the next
        clear_logs(); push(0, 0, 16, 0, 0); push(1, 0, 24, 0, 0); run(50);
        chk("t3_nacks", ack_p_log.size(), 2);
        if (ack_p_log.size() == 2) begin
            chk("t3_first", ack_p_log[0], 0);
            chk("t3_cpu_rd", ack_rd_log[0], 32'h3);
            chk("t3_aux_rd", ack_rd_log[1], 32'h4);
            chk("t3_gap", ack_cyc_log[1] - ack_cyc_log[0], 2);
        end
        clear_logs(); push(0, 0, 0, 0, 0); push(1, 0, 8, 0, 0); run(50);
        chk("t3b_first", (ack_p_log.size() > 0) ? ack_p_log[0] : -1, 1);

        // continuous requests on both ports: strict alternation, one ack per 2 cycles
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push(0, 0, $urandom_range(MAXA), 0, 0);
            push(1, 0, $urandom_range(MAXA), 0, 0);
        end
        run(100);
        chk("t4_nacks", ack_p_log.size(), 8);
        for (int i = 1; i < ack_p_log.size(); i++) begin
            chk("t4_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 2);
            chk("t4_alternate", ack_p_log[i] != ack_p_log[i-1], 1);
        end

        // write near the top of memory
        clear_logs(); push(1, 1, 60, 32'h12345678, 0); run(50);
        chk("t5_err", (ack_err_log.size() > 0) ? ack_err_log[0] : 32'hX, BCHK);
        chk("t5_mem", dev_word(56), BCHK ? 32'h8 : 32'h5678_0008);

        // reset asserted mid-grant of a write: nothing commits, outputs back to reset
        cpu_we = 1; cpu_addr = 32; cpu_wdata = 32'hAAAA5555; cpu_req = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!mem_memorywrite && n < 10);
        chk("t6_gnt_wr", mem_memorywrite, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_wr", mem_memorywrite, 0);
        chk("t6_rst_addr", mem_address, 0);
        chk("t6_rst_ack", {cpu_ack, aux_ack, cpu_err, aux_err}, 0);
        chk("t6_rst_rdata", cpu_rdata | aux_rdata, 0);
        cpu_req = 0;
        @(posedge clk); #3;
        chk("t6_mem", dev_word(32), 32'h5);
        reset_n = 1'b1;
        model_reset();
        push(0, 0, 32, 0, 0); run(50);
        chk("t6_read", cpu_rdata, 32'h5);

        // randomized traffic on both ports
        for (int i = 0; i < 150; i++)
            for (int p = 0; p < 2; p++) begin
                ra = $urandom_range(MAXA);
                if (BCHK && ($urandom % 8 == 0))
                    ra = ($urandom % 2) ? 32'(MAXA + 1 + $urandom_range(6)) : 32'hFFFF_FFF8 + ($urandom % 8);
                push(p, $urandom % 2, ra, $urandom, $urandom_range(3));
            end
        run(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
